lif_spike_monitor: RTL and testbench
====================================

Name: lif_spike_monitor

Overview:
- Downstream consumer of the LIF neuron's 1-bit spike output.
- Measures firing rate as spikes per programmable window and presents it on a valid/ready port for readout logic or the bidirectional pins.
- Also reports the inter-spike interval (ISI) in cycles for each spike and raises a burst flag.
- Gives the team observability of neuron dynamics beyond the raw membrane state.

Parameters:
- WINDOW_W, 8, width of window length and window cycle counter.
- COUNT_W, 8, width of spike count / rate_out; saturates at 2^COUNT_W-1.
- ISI_W, 8, width of ISI counter / isi_out; saturates at 2^ISI_W-1.
- BURST_ISI, 4, ISI strictly below this value is a burst spike.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  monitoring enable; low = idle.
- spike_in  input  1  spike from LIF neuron, one-cycle pulse per spike, sampled every cycle.
- window_len  input  WINDOW_W  window length in cycles; captured at window start.
- rate_out  output  COUNT_W  spike count of the last completed window.
- rate_valid  output  1  rate_out holds an unconsumed result.
- rate_ready  input  1  consumer accepts rate_out when high with rate_valid.
- isi_out  output  ISI_W  cycles since the previous spike, registered.
- isi_valid  output  1  one-cycle pulse: isi_out updated.
- burst  output  1  high one cycle with isi_valid when isi_out < BURST_ISI.
- overrun  output  1  sticky: a completed window was dropped.

Behaviour:
- Reset (async, any time including mid-window): every output 0; win_cnt, spk_cnt, isi_cnt, win_len_q = 0; have_prev = 0; state = IDLE.
- States:
  - IDLE: entered on reset or enable low.
  - COUNT: windowing active.
- IDLE→COUNT: on the first cycle with enable = 1. That cycle captures win_len_q (window_len == 0 is treated as 1), sets win_cnt = 0, and counts spike_in.
- COUNT→IDLE: when enable = 0.
  - The partial window is discarded and spk_cnt is cleared.
  - have_prev clears; isi_cnt clears.
  - A pending rate_out/rate_valid is kept.
- Window: in COUNT, each cycle spk_cnt += spike_in, saturating.
- Window close: on the cycle win_cnt == win_len_q-1, the final count (spk_cnt + spike_in, saturated) is the window result.
  - The same cycle, win_cnt and spk_cnt restart at 0 and window_len is recaptured. Windows are back-to-back with no gap cycle.
- Rate output, one-entry buffer:
  - Result is registered; rate_valid rises the cycle after the close.
  - rate_out stays stable while rate_valid = 1.
  - Handshake completes on a cycle with rate_valid & rate_ready; rate_valid drops the next cycle unless a new result is loaded that same cycle.
  - A close coinciding with a handshake loads the new result; rate_valid stays 1.
  - A close while rate_valid = 1 and rate_ready = 0 drops the new result, keeps the old one, and sets overrun. overrun is cleared only by rst.
- ISI:
  - isi_cnt increments every COUNT cycle, saturating at max.
  - On spike_in = 1 with have_prev = 1: next cycle isi_out = isi_cnt + 1 (saturating), isi_valid = 1, and burst = (that value < BURST_ISI).
  - On every spike in COUNT, isi_cnt resets to 0 and have_prev sets.
  - The first spike after reset or enable produces no isi_valid.
  - Back-to-back spikes give isi_out = 1.
  - isi_out holds its value between pulses.
- Latency: rate 1 cycle after close; ISI 1 cycle after spike.
- spike_in while IDLE is ignored.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst mid-window with rate_valid = 1, then release with enable = 0.
  - Required: all outputs 0 and remain 0 while spikes toggle.
- Basic rate:
  - Stimulus: window_len = 10, enable = 1, rate_ready = 1, spikes on cycles 0, 3, 9.
  - Required: rate_out = 3, rate_valid high for one cycle at cycle 10.
  - Required: the next window starts at cycle 10 with no gap.
- Backpressure/overrun:
  - Stimulus: window_len = 4, rate_ready = 0, 2 spikes in window 1 and 4 spikes in window 2.
  - Required: rate_out stays 2, overrun = 1 after the second close.
  - Required: raising rate_ready gives one handshake, then rate_valid = 0.
- Saturation/edge:
  - Stimulus: window_len = 0 with spikes every cycle.
  - Required: rate_out = 1 every cycle.
  - Stimulus: window_len = 255 with spikes every cycle.
  - Required: rate_out = 255.
- ISI/burst:
  - Stimulus: spikes at cycles 5, 6, 12 after enable.
  - Required: no ISI on the first spike; isi_out = 1 with burst = 1; then isi_out = 6 with burst = 0.
  - Stimulus: no spikes for 300 cycles, then a spike.
  - Required: isi_out = 255.
- Enable drop:
  - Stimulus: deassert enable mid-window, then re-enable.
  - Required: the partial count is discarded, the first spike after re-enable gives no isi_valid, and a pending rate_out is preserved.

Source files
------------

// File: rtl/lif_spike_monitor.sv
// Purpose: spike-rate (spikes per programmable window) and inter-spike-interval monitor for one LIF neuron.
// Latency: a rate result appears 1 cycle after its window closes; ISI and burst appear 1 cycle after the spike.
// Backpressure: one-entry rate buffer; a window that closes while the buffer is full and not being read is dropped and sets sticky overrun.
module lif_spike_monitor #(
   parameter int WINDOW_W  = 8,
   parameter int COUNT_W   = 8,
   parameter int ISI_W     = 8,
   parameter int BURST_ISI = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                spike_in,
   input  logic [WINDOW_W-1:0] window_len,
   output logic [COUNT_W-1:0]  rate_out,
   output logic                rate_valid,
   input  logic                rate_ready,
   output logic [ISI_W-1:0]    isi_out,
   output logic                isi_valid,
   output logic                burst,
   output logic                overrun
);

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   // One extra bit so a threshold equal to 2^ISI_W still means "every interval is a burst".
   localparam logic [ISI_W:0] BURST_TH = (ISI_W + 1)'(BURST_ISI);

   state_t              state;
   logic [WINDOW_W-1:0] win_cnt;
   logic [WINDOW_W-1:0] win_len_q;
   logic [COUNT_W-1:0]  spk_cnt;
   logic [ISI_W-1:0]    isi_cnt;
   logic                have_prev;

   logic [WINDOW_W-1:0] len_eff;
   logic [WINDOW_W-1:0] cur_len;
   logic [WINDOW_W-1:0] cur_cnt;
   logic [COUNT_W-1:0]  cur_spk;
   logic [COUNT_W-1:0]  spk_next;
   logic [ISI_W-1:0]    isi_next;
   logic                win_close;
   logic                rate_hs;
   logic                rate_load;

   // Window bookkeeping as seen this cycle; the first enabled cycle behaves as cycle 0 of a freshly captured window.
   always_comb begin
      len_eff   = (window_len == '0) ? WINDOW_W'(1) : window_len;
      cur_len   = (state == IDLE) ? len_eff : win_len_q;
      cur_cnt   = (state == IDLE) ? '0 : win_cnt;
      cur_spk   = (state == IDLE) ? '0 : spk_cnt;
      spk_next  = (spike_in && (cur_spk != '1)) ? cur_spk + COUNT_W'(1) : cur_spk;
      isi_next  = (isi_cnt != '1) ? isi_cnt + ISI_W'(1) : isi_cnt;
      win_close = enable && (cur_cnt == cur_len - WINDOW_W'(1));
      rate_hs   = rate_valid && rate_ready;
      rate_load = win_close && (!rate_valid || rate_ready);
   end

   // Control FSM and window counters: windows run back-to-back, a drop of enable discards the partial window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         win_cnt   <= '0;
         win_len_q <= '0;
         spk_cnt   <= '0;
      end else if (!enable) begin
         state   <= IDLE;
         win_cnt <= '0;
         spk_cnt <= '0;
      end else begin
         state <= COUNT;
         if (win_close) begin
            // Restart in the same cycle and pick up the next window length.
            win_cnt   <= '0;
            spk_cnt   <= '0;
            win_len_q <= len_eff;
         end else begin
            win_cnt   <= cur_cnt + WINDOW_W'(1);
            spk_cnt   <= spk_next;
            win_len_q <= cur_len;
         end
      end
   end

   // Inter-spike interval: counts cycles since the last spike and reports it on every spike that has a predecessor.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         isi_cnt   <= '0;
         have_prev <= 1'b0;
         isi_out   <= '0;
         isi_valid <= 1'b0;
         burst     <= 1'b0;
      end else begin
         isi_valid <= 1'b0;
         burst     <= 1'b0;
         if (!enable) begin
            // Leaving the active state forgets the previous spike, so the next one starts a fresh interval.
            isi_cnt   <= '0;
            have_prev <= 1'b0;
         end else if (spike_in) begin
            isi_cnt   <= '0;
            have_prev <= 1'b1;
            if (have_prev) begin
               isi_out   <= isi_next;
               isi_valid <= 1'b1;
               burst     <= ({1'b0, isi_next} < BURST_TH);
            end
         end else begin
            isi_cnt <= isi_next;
         end
      end
   end

   // One-entry rate buffer: load on close when free or being drained, otherwise drop the result and flag overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rate_out   <= '0;
         rate_valid <= 1'b0;
         overrun    <= 1'b0;
      end else if (rate_load) begin
         rate_out   <= spk_next;
         rate_valid <= 1'b1;
      end else if (win_close) begin
         overrun <= 1'b1;
      end else if (rate_hs) begin
         rate_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lif_spike_monitor.sv
module tb_lif_spike_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enable = 1'b0;
   logic       spike_in = 1'b0;
   logic [7:0] window_len = 8'd0;
   logic [7:0] rate_out;
   logic       rate_valid;
   logic       rate_ready = 1'b0;
   logic [7:0] isi_out;
   logic       isi_valid;
   logic       burst;
   logic       overrun;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: time-stamp based (window start cycle, last spike cycle), not a copy of the counters.
   int   cyc;
   bit   active;
   int   win_start;
   int   win_len;
   int   win_spk;
   int   last_spk;
   logic [7:0] e_rate;
   logic [7:0] e_isi;
   bit   e_rvld, e_ivld, e_burst, e_ovr;

   lif_spike_monitor dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .spike_in   (spike_in),
      .window_len (window_len),
      .rate_out   (rate_out),
      .rate_valid (rate_valid),
      .rate_ready (rate_ready),
      .isi_out    (isi_out),
      .isi_valid  (isi_valid),
      .burst      (burst),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   function automatic int eff_len(input logic [7:0] l);
      return (l == 8'd0) ? 1 : int'(l);
   endfunction

   task automatic mdl_reset();
      cyc = 0; active = 0; win_start = 0; win_len = 1; win_spk = 0; last_spk = -1;
      e_rate = 8'd0; e_isi = 8'd0; e_rvld = 0; e_ivld = 0; e_burst = 0; e_ovr = 0;
   endtask

   task automatic mdl_step();
      bit hs;
      bit close;
      int res;
      int d;
      hs = e_rvld && rate_ready;
      close = 0;
      res = 0;
      e_ivld = 0;
      e_burst = 0;
      if (!enable) begin
         active = 0;
         last_spk = -1;
      end else begin
         if (!active) begin
            active = 1; win_start = cyc; win_len = eff_len(window_len); win_spk = 0;
         end
         if (spike_in) begin
            win_spk++;
            if (last_spk >= 0) begin
               d = cyc - last_spk;
               e_isi = (d > 255) ? 8'd255 : 8'(d);
               e_ivld = 1;
               e_burst = (d < 4);
            end
            last_spk = cyc;
         end
         if (cyc - win_start == win_len - 1) begin
            close = 1;
            res = (win_spk > 255) ? 255 : win_spk;
            win_start = cyc + 1;
            win_len = eff_len(window_len);
            win_spk = 0;
         end
      end
      if (close) begin
         if (!e_rvld || rate_ready) begin
            e_rate = 8'(res);
            e_rvld = 1;
         end else begin
            e_ovr = 1;
         end
      end else if (hs) begin
         e_rvld = 0;
      end
      cyc++;
   endtask

   task automatic tick();
      @(posedge clk);
      mdl_step();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; spike_in = 1'b0; rate_ready = 1'b0; window_len = 8'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      mdl_reset();
   endtask

   task automatic test_reset();
      do_reset();
      enable = 1'b1; window_len = 8'd3; spike_in = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_cmp++;
         if ({rate_valid, rate_out, isi_valid, isi_out, burst, overrun} !== {e_rvld, e_rate, e_ivld, e_isi, e_burst, e_ovr}) begin
            n_err++;
            $display("FAIL reset_pre k=%0d got=%h want=%h", k, {rate_valid, rate_out, isi_valid, isi_out, burst, overrun}, {e_rvld, e_rate, e_ivld, e_isi, e_burst, e_ovr});
         end
      end
      n_cmp++;
      if (rate_valid !== 1'b1) begin
         n_err++;
         $display("FAIL reset_setup rate_valid got=%b want=1", rate_valid);
      end
      #3 rst = 1'b1;
      #1;
      n_cmp++;
      if ({rate_valid, rate_out, isi_valid, isi_out, burst, overrun} !== 19'd0) begin
         n_err++;
         $display("FAIL reset_async got=%h want=0", {rate_valid, rate_out, isi_valid, isi_out, burst, overrun});
      end
      mdl_reset();
      @(posedge clk);
      #1;
      rst = 1'b0; enable = 1'b0;
      for (int k = 0; k < 6; k++) begin
         spike_in = ~spike_in;
         tick();
         n_cmp++;
         if ({rate_valid, rate_out, isi_valid, isi_out, burst, overrun} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_idle k=%0d got=%h want=0", k, {rate_valid, rate_out, isi_valid, isi_out, burst, overrun});
         end
      end
   endtask

   task automatic test_basic_rate();
      do_reset();
      enable = 1'b1; window_len = 8'd10; rate_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         spike_in = (k == 0 || k == 3 || k == 9);
         tick();
         n_cmp++;
         if ({rate_valid, rate_out, isi_valid, isi_out, burst, overrun} !== {e_rvld, e_rate, e_ivld, e_isi, e_burst, e_ovr}) begin
            n_err++;
            $display("FAIL basic_model k=%0d got=%h want=%h", k, {rate_valid, rate_out, isi_valid, isi_out, burst, overrun}, {e_rvld, e_rate, e_ivld, e_isi, e_burst, e_ovr});
         end
         if (k == 9) begin
            n_cmp++;
            if (rate_valid !== 1'b1 || rate_out !== 8'd3) begin
               n_err++;
               $display("FAIL basic_close got v=%b r=%0d want v=1 r=3", rate_valid, rate_out);
            end
         end
         if (k == 10) begin
            n_cmp++;
            if (rate_valid !== 1'b0) begin
               n_err++;
               $display("FAIL basic_onepulse rate_valid got=%b want=0", rate_valid);
            end
         end
         if (k == 19) begin
            n_cmp++;
            if (rate_valid !== 1'b1 || rate_out !== 8'd0) begin
               n_err++;
               $display("FAIL basic_nogap got v=%b r=%0d want v=1 r=0", rate_valid, rate_out);
            end
         end
      end
   endtask

   task automatic test_overrun();
      do_reset();
      enable = 1'b1; window_len = 8'd4; rate_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         spike_in = (k < 8) && ((k < 2) || (k >= 4));
         enable = (k < 8);
         rate_ready = (k == 8);
         tick();
         n_cmp++;
         if ({rate_valid, rate_out, isi_valid, isi_out, burst, overrun} !== {e_rvld, e_rate, e_ivld, e_isi, e_burst, e_ovr}) begin
            n_err++;
            $display("FAIL ovr_model k=%0d got=%h want=%h", k, {rate_valid, rate_out, isi_valid, isi_out, burst, overrun}, {e_rvld, e_rate, e_ivld, e_isi, e_burst, e_ovr});
         end
         if (k == 7) begin
            n_cmp++;
            if (rate_valid !== 1'b1 || rate_out !== 8'd2 || overrun !== 1'b1) begin
               n_err++;
               $display("FAIL ovr_hold got v=%b r=%0d o=%b want v=1 r=2 o=1", rate_valid, rate_out, overrun);
            end
         end
         if (k == 8 || k == 9) begin
            n_cmp++;
            if (rate_valid !== 1'b0 || overrun !== 1'b1) begin
               n_err++;
               $display("FAIL ovr_drain k=%0d got v=%b o=%b want v=0 o=1", k, rate_valid, overrun);
            end
         end
      end
   endtask

   task automatic test_edge();
      do_reset();
      enable = 1'b1; window_len = 8'd0; rate_ready = 1'b1; spike_in = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         n_cmp++;
         if (rate_valid !== 1'b1 || rate_out !== 8'd1) begin
            n_err++;
            $display("FAIL edge_len0 k=%0d got v=%b r=%0d want v=1 r=1", k, rate_valid, rate_out);
         end
      end
      do_reset();
      enable = 1'b1; window_len = 8'd255; rate_ready = 1'b1; spike_in = 1'b1;
      for (int k = 0; k < 256; k++) begin
         tick();
         n_cmp++;
         if ({rate_valid, rate_out, isi_valid, isi_out, burst, overrun} !== {e_rvld, e_rate, e_ivld, e_isi, e_burst, e_ovr}) begin
            n_err++;
            $display("FAIL edge_model k=%0d got=%h want=%h", k, {rate_valid, rate_out, isi_valid, isi_out, burst, overrun}, {e_rvld, e_rate, e_ivld, e_isi, e_burst, e_ovr});
         end
         if (k == 254) begin
            n_cmp++;
            if (rate_valid !== 1'b1 || rate_out !== 8'd255) begin
               n_err++;
               $display("FAIL edge_len255 got v=%b r=%0d want v=1 r=255", rate_valid, rate_out);
            end
         end
      end
   endtask

   task automatic test_isi_burst();
      do_reset();
      enable = 1'b1; window_len = 8'd50; rate_ready = 1'b1;
      for (int k = 0; k < 315; k++) begin
         spike_in = (k == 5 || k == 6 || k == 12 || k == 313);
         tick();
         n_cmp++;
         if ({rate_valid, rate_out, isi_valid, isi_out, burst, overrun} !== {e_rvld, e_rate, e_ivld, e_isi, e_burst, e_ovr}) begin
            n_err++;
            $display("FAIL isi_model k=%0d got=%h want=%h", k, {rate_valid, rate_out, isi_valid, isi_out, burst, overrun}, {e_rvld, e_rate, e_ivld, e_isi, e_burst, e_ovr});
         end
         if (k == 5) begin
            n_cmp++;
            if (isi_valid !== 1'b0) begin
               n_err++;
               $display("FAIL isi_first got isi_valid=%b want 0", isi_valid);
            end
         end
         if (k == 6) begin
            n_cmp++;
            if (isi_valid !== 1'b1 || isi_out !== 8'd1 || burst !== 1'b1) begin
               n_err++;
               $display("FAIL isi_b2b got v=%b isi=%0d b=%b want v=1 isi=1 b=1", isi_valid, isi_out, burst);
            end
         end
         if (k == 12) begin
            n_cmp++;
            if (isi_valid !== 1'b1 || isi_out !== 8'd6 || burst !== 1'b0) begin
               n_err++;
               $display("FAIL isi_six got v=%b isi=%0d b=%b want v=1 isi=6 b=0", isi_valid, isi_out, burst);
            end
         end
         if (k == 13) begin
            n_cmp++;
            if (isi_valid !== 1'b0 || isi_out !== 8'd6) begin
               n_err++;
               $display("FAIL isi_hold got v=%b isi=%0d want v=0 isi=6", isi_valid, isi_out);
            end
         end
         if (k == 313) begin
            n_cmp++;
            if (isi_valid !== 1'b1 || isi_out !== 8'd255) begin
               n_err++;
               $display("FAIL isi_sat got v=%b isi=%0d want v=1 isi=255", isi_valid, isi_out);
            end
         end
      end
   endtask

   task automatic test_enable_drop();
      do_reset();
      window_len = 8'd8;
      for (int k = 0; k < 23; k++) begin
         enable = !(k >= 11 && k <= 13);
         spike_in = (k == 0 || k == 1 || k == 2 || k == 8 || k == 9 || k == 12 || k == 14 || k == 16);
         rate_ready = (k == 20);
         tick();
         n_cmp++;
         if ({rate_valid, rate_out, isi_valid, isi_out, burst, overrun} !== {e_rvld, e_rate, e_ivld, e_isi, e_burst, e_ovr}) begin
            n_err++;
            $display("FAIL drop_model k=%0d got=%h want=%h", k, {rate_valid, rate_out, isi_valid, isi_out, burst, overrun}, {e_rvld, e_rate, e_ivld, e_isi, e_burst, e_ovr});
         end
         if (k == 13) begin
            n_cmp++;
            if (rate_valid !== 1'b1 || rate_out !== 8'd3) begin
               n_err++;
               $display("FAIL drop_pending got v=%b r=%0d want v=1 r=3", rate_valid, rate_out);
            end
         end
         if (k == 14) begin
            n_cmp++;
            if (isi_valid !== 1'b0) begin
               n_err++;
               $display("FAIL drop_first_isi got isi_valid=%b want 0", isi_valid);
            end
         end
         if (k == 16) begin
            n_cmp++;
            if (isi_valid !== 1'b1 || isi_out !== 8'd2) begin
               n_err++;
               $display("FAIL drop_isi got v=%b isi=%0d want v=1 isi=2", isi_valid, isi_out);
            end
         end
         if (k == 21) begin
            n_cmp++;
            if (rate_valid !== 1'b1 || rate_out !== 8'd2 || overrun !== 1'b0) begin
               n_err++;
               $display("FAIL drop_partial got v=%b r=%0d o=%b want v=1 r=2 o=0", rate_valid, rate_out, overrun);
            end
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 1500; k++) begin
         enable = ($urandom_range(0, 99) < 97);
         spike_in = ($urandom_range(0, 2) == 0);
         rate_ready = ($urandom_range(0, 1) == 1);
         window_len = 8'($urandom_range(0, 6));
         tick();
         n_cmp++;
         if ({rate_valid, rate_out, isi_valid, isi_out, burst, overrun} !== {e_rvld, e_rate, e_ivld, e_isi, e_burst, e_ovr}) begin
            n_err++;
            $display("FAIL rand_model k=%0d got=%h want=%h", k, {rate_valid, rate_out, isi_valid, isi_out, burst, overrun}, {e_rvld, e_rate, e_ivld, e_isi, e_burst, e_ovr});
         end
      end
   endtask

   initial begin
      mdl_reset();
      #2;
      test_reset();
      test_basic_rate();
      test_overrun();
      test_edge();
      test_isi_burst();
      test_enable_drop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
